adder: RTL and testbench

ADDER -- requirements
Module: adder

---
 rtl/adder_pkg.sv | 18 +
 rtl/adder_align.sv | 13 +
 rtl/adder.sv | 129 ++++++++++++
 tb/tb_adder.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared widths, limits and the stage-1 pipeline record for the two-stage
// sign/magnitude adder. Optional left normalization: ADDER_NORMALIZE_EN.
package adder_pkg;

   localparam int EXP_W = 6;
   localparam int MAN_W = 12;
   localparam logic [EXP_W-1:0] EXP_MAX = 6'd63;
   localparam logic [EXP_W-1:0] ALIGN_LIMIT = 6'd12;

   typedef struct packed {
      logic             sign;
      logic [EXP_W-1:0] exponent;
      logic [MAN_W-1:0] man_large;
      logic [MAN_W-1:0] man_small;
      logic             subtract;
   } stage1_t;

endpackage

// File: rtl/adder_align.sv
// Combinational right shifter that aligns the smaller mantissa; bits shifted
// out are dropped and shifts of ALIGN_LIMIT or more give zero.
module adder_align
   import adder_pkg::*;
(
   input  logic [MAN_W-1:0] i_mantissa,
   input  logic [EXP_W-1:0] i_shift,
   output logic [MAN_W-1:0] o_mantissa
);

   assign o_mantissa = (i_shift >= ALIGN_LIMIT) ? '0 : (i_mantissa >> i_shift);

endmodule

// File: rtl/adder.sv
// Two-stage sign/magnitude adder: stage 1 compares and aligns, stage 2 adds or
// subtracts and registers the result. ADDER_NORMALIZE_EN adds left normalization.
module adder
   import adder_pkg::*;
(
   input  logic             i_clock,
   input  logic             i_reset_n,
   input  logic             i_sign_a,
   input  logic             i_sign_b,
   input  logic [EXP_W-1:0] i_exponent_a,
   input  logic [EXP_W-1:0] i_exponent_b,
   input  logic [MAN_W-1:0] i_mantissa_a,
   input  logic [MAN_W-1:0] i_mantissa_b,
   output logic             o_sign_out,
   output logic [EXP_W-1:0] o_exponent_out,
   output logic [MAN_W-1:0] o_mantissa_out,
   output logic             o_cout
);

   logic             w_a_larger;
   logic [EXP_W-1:0] w_shift;
   logic [MAN_W-1:0] w_small_raw;
   logic [MAN_W-1:0] w_small_aligned;
   stage1_t          w_stage1_next;
   stage1_t          r_stage1;

   // Full tie (same exponent and mantissa) favours A.
   assign w_a_larger = (i_exponent_a > i_exponent_b) ||
                       ((i_exponent_a == i_exponent_b) && (i_mantissa_a >= i_mantissa_b));
   assign w_shift = w_a_larger ? (i_exponent_a - i_exponent_b) : (i_exponent_b - i_exponent_a);
   assign w_small_raw = w_a_larger ? i_mantissa_b : i_mantissa_a;

   adder_align u_align (
      .i_mantissa (w_small_raw),
      .i_shift    (w_shift),
      .o_mantissa (w_small_aligned)
   );

   always_comb begin
      w_stage1_next.sign      = w_a_larger ? i_sign_a : i_sign_b;
      w_stage1_next.exponent  = w_a_larger ? i_exponent_a : i_exponent_b;
      w_stage1_next.man_large = w_a_larger ? i_mantissa_a : i_mantissa_b;
      w_stage1_next.man_small = w_small_aligned;
      w_stage1_next.subtract  = i_sign_a ^ i_sign_b;
   end

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_stage1 <= '0;
      end else begin
         r_stage1 <= w_stage1_next;
      end
   end

   logic [MAN_W:0]   w_sum;
   logic [MAN_W-1:0] w_diff;
   logic             w_res_sign;
   logic [EXP_W-1:0] w_res_exp;
   logic [MAN_W-1:0] w_res_man;
   logic             w_res_cout;
   logic [EXP_W-1:0] w_fin_exp;
   logic [MAN_W-1:0] w_fin_man;

   assign w_sum  = {1'b0, r_stage1.man_large} + {1'b0, r_stage1.man_small};
   // Larger-by-exponent can hold a smaller mantissa; the difference wraps modulo 2^12.
   assign w_diff = r_stage1.man_large - r_stage1.man_small;

   always_comb begin
      w_res_sign = r_stage1.sign;
      w_res_exp  = r_stage1.exponent;
      w_res_man  = w_sum[MAN_W-1:0];
      w_res_cout = 1'b0;
      if (r_stage1.subtract) begin
         w_res_man = w_diff;
         if (w_diff == '0) begin
            w_res_sign = 1'b0;
         end
      end else if (w_sum[MAN_W]) begin
         w_res_cout = 1'b1;
         if (r_stage1.exponent == EXP_MAX) begin
            w_res_man = '1;
         end else begin
            w_res_man = w_sum[MAN_W:1];
            w_res_exp = r_stage1.exponent + 6'd1;
         end
      end
   end

`ifdef ADDER_NORMALIZE_EN
   always_comb begin
      w_fin_exp = w_res_exp;
      w_fin_man = w_res_man;
      for (int i = 0; i < MAN_W; i++) begin
         if ((w_fin_man != '0) && !w_fin_man[MAN_W-1] && (w_fin_exp != '0)) begin
            w_fin_man = w_fin_man << 1;
            w_fin_exp = w_fin_exp - 6'd1;
         end
      end
   end
`else
   assign w_fin_exp = w_res_exp;
   assign w_fin_man = w_res_man;
`endif

   logic             r_sign_out;
   logic [EXP_W-1:0] r_exponent_out;
   logic [MAN_W-1:0] r_mantissa_out;
   logic             r_cout;

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_sign_out     <= 1'b0;
         r_exponent_out <= '0;
         r_mantissa_out <= '0;
         r_cout         <= 1'b0;
      end else begin
         r_sign_out     <= w_res_sign;
         r_exponent_out <= w_fin_exp;
         r_mantissa_out <= w_fin_man;
         r_cout         <= w_res_cout;
      end
   end

   assign o_sign_out     = r_sign_out;
   assign o_exponent_out = r_exponent_out;
   assign o_mantissa_out = r_mantissa_out;
   assign o_cout         = r_cout;

endmodule

// File: tb/tb_adder.sv
// Self-checking bench for adder: directed and random vectors against an
// arithmetic reference, expected results queued for the two-cycle latency.
module tb_adder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        sa = 1'b0, sb = 1'b0;
   logic [5:0]  ea = '0, eb = '0;
   logic [11:0] ma = '0, mb = '0;
   logic        so;
   logic [5:0]  eo;
   logic [11:0] mo;
   logic        co;

   int n_pass = 0;
   int n_total = 0;
   logic [19:0] q_exp[$];
   logic [19:0] obs;
   logic [19:0] req;

   always #5 clk = ~clk;

   adder dut (
      .i_clock        (clk),
      .i_reset_n      (rst_n),
      .i_sign_a       (sa),
      .i_sign_b       (sb),
      .i_exponent_a   (ea),
      .i_exponent_b   (eb),
      .i_mantissa_a   (ma),
      .i_mantissa_b   (mb),
      .o_sign_out     (so),
      .o_exponent_out (eo),
      .o_mantissa_out (mo),
      .o_cout         (co)
   );

   // Reference: value semantics M*2^E computed with plain integer arithmetic.
   function automatic logic [19:0] model(input logic s_a, input logic [5:0] e_a, input logic [11:0] m_a,
                                         input logic s_b, input logic [5:0] e_b, input logic [11:0] m_b);
      int el, es, ml, ms, sh, m, e;
      logic sl, s, c;
      if (e_a > e_b || (e_a == e_b && m_a >= m_b)) begin
         el = int'(e_a); es = int'(e_b); ml = int'(m_a); ms = int'(m_b); sl = s_a;
      end else begin
         el = int'(e_b); es = int'(e_a); ml = int'(m_b); ms = int'(m_a); sl = s_b;
      end
      sh = el - es;
      ms = (sh >= 12) ? 0 : (ms >> sh);
      c = 1'b0;
      e = el;
      s = sl;
      if (s_a == s_b) begin
         m = ml + ms;
         if (m > 4095) begin
            c = 1'b1;
            if (el == 63) m = 4095;
            else begin m = m / 2; e = el + 1; end
         end
      end else begin
         m = ml - ms;
         if (m < 0) m = m + 4096;
         if (m == 0) s = 1'b0;
      end
`ifdef ADDER_NORMALIZE_EN
      while (m != 0 && m < 2048 && e > 0) begin
         m = m * 2;
         e = e - 1;
      end
`endif
      return {s, 6'(e), 12'(m), c};
   endfunction

   task automatic check(input string tag, input logic [19:0] o, input logic [19:0] r);
      n_total++;
      assert (o === r) n_pass++;
      else $error("FAIL %s: got s=%0b e=%0d m=%03h c=%0b, required s=%0b e=%0d m=%03h c=%0b",
                  tag, o[19], o[18:13], o[12:1], o[0], r[19], r[18:13], r[12:1], r[0]);
   endtask

   // Drive one input set, advance one edge, check the result due this cycle.
   task automatic step(input string tag, input logic s_a, input logic [5:0] e_a, input logic [11:0] m_a,
                       input logic s_b, input logic [5:0] e_b, input logic [11:0] m_b);
      sa = s_a; ea = e_a; ma = m_a;
      sb = s_b; eb = e_b; mb = m_b;
      q_exp.push_back(model(s_a, e_a, m_a, s_b, e_b, m_b));
      @(posedge clk);
      #1;
      if (q_exp.size() == 2) begin
         req = q_exp.pop_front();
         obs = {so, eo, mo, co};
         $display("txn %s: out s=%0b e=%0d m=%03h c=%0b", tag, so, eo, mo, co);
         check(tag, obs, req);
      end
   endtask

   initial begin
      #2;
      check("reset_state", {so, eo, mo, co}, 20'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      step("eq_exp_add",  1'b0, 6'd7,  12'h03F, 1'b0, 6'd7,  12'h1DC);
      step("carry",       1'b0, 6'd3,  12'hFFF, 1'b0, 6'd3,  12'hFFF);
      step("carry_sat",   1'b0, 6'd63, 12'hFFF, 1'b0, 6'd63, 12'hFFF);
      step("align_sub",   1'b0, 6'd4,  12'h100, 1'b1, 6'd2,  12'h100);
      step("b_larger",    1'b0, 6'd4,  12'h100, 1'b1, 6'd16, 12'h100);
      step("cancel",      1'b0, 6'd9,  12'h2A5, 1'b1, 6'd9,  12'h2A5);
      step("tie_neg_a",   1'b1, 6'd5,  12'h123, 1'b1, 6'd5,  12'h123);
      step("shift11",     1'b1, 6'd20, 12'h800, 1'b1, 6'd9,  12'hFFF);
      step("zero_ops",    1'b1, 6'd0,  12'h000, 1'b0, 6'd0,  12'h000);
      step("flush",       1'b0, 6'd1,  12'h001, 1'b0, 6'd1,  12'h001);

      // Asynchronous reset between edges with results still in flight.
      #2;
      rst_n = 1'b0;
      #1;
      check("async_clear", {so, eo, mo, co}, 20'h0);
      q_exp.delete();
      @(posedge clk); #1;
      check("held_clear", {so, eo, mo, co}, 20'h0);
      rst_n = 1'b1;
      step("post_rst_a",  1'b0, 6'd7,  12'h03F, 1'b0, 6'd7,  12'h1DC);
      step("post_rst_b",  1'b1, 6'd10, 12'h400, 1'b0, 6'd12, 12'h100);

      for (int i = 0; i < 200; i++) begin
         logic [5:0] r_ea, r_eb;
         logic [11:0] r_ma, r_mb;
         r_ea = 6'($urandom_range(0, 63));
         r_eb = ($urandom_range(0, 3) == 0) ? r_ea : 6'($urandom_range(0, 63));
         if ($urandom_range(0, 7) == 0) begin r_ea = 6'd63; r_eb = 6'd63; end
         r_ma = 12'($urandom);
         r_mb = ($urandom_range(0, 7) == 0) ? r_ma : 12'($urandom);
         if ($urandom_range(0, 3) == 0) begin r_eb = r_ea - 6'($urandom_range(0, 3)); end
         step("random", 1'($urandom), r_ea, r_ma, 1'($urandom), r_eb, r_mb);
      end
      step("drain", 1'b0, 6'd0, 12'h000, 1'b0, 6'd0, 12'h000);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, passed %0d of %0d", n_pass, n_total);
      $fatal(1, "timeout");
   end

endmodule
